// File: rtl/accel_seq_alu.sv
// Sequential 8-bit ALU: single-cycle add/sub/logic, 8-step shift-add MUL and restoring DIV.
// The divider is built only when ACCEL_SEQ_ALU_DIV_EN is defined; otherwise opcode 3 is illegal.
module accel_seq_alu (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  input  logic [3:0]  opcode,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic        err
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state, state_nxt;
  logic [7:0]  a_r, b_r;
  logic [2:0]  cnt;
  logic [15:0] acc, acc_nxt;
  logic        multi;
  logic [15:0] sc_res;
  logic        sc_err;

`ifdef ACCEL_SEQ_ALU_DIV_EN
  logic       is_div_r;
  logic [7:0] rem, quo, rem_nxt, quo_nxt;
  logic [8:0] rem_sh, rem_sub;

  assign multi = (opcode == 4'd2) || (opcode == 4'd3);

  // One restoring step: shift next dividend bit into the partial remainder.
  // With b=0 every subtract succeeds, yielding quotient 0xFF and remainder a.
  always_comb begin
    rem_sh  = {rem, quo[7]};
    rem_sub = rem_sh - {1'b0, b_r};
    if (rem_sh >= {1'b0, b_r}) begin
      rem_nxt = rem_sub[7:0];
      quo_nxt = {quo[6:0], 1'b1};
    end else begin
      rem_nxt = rem_sh[7:0];
      quo_nxt = {quo[6:0], 1'b0};
    end
  end
`else
  assign multi = (opcode == 4'd2);
`endif

  assign acc_nxt = b_r[cnt] ? acc + ({8'd0, a_r} << cnt) : acc;

  always_comb begin
    sc_res = 16'd0;
    sc_err = 1'b0;
    case (opcode)
      4'd0:    sc_res = {8'd0, a} + {8'd0, b};
      4'd1:    sc_res = {8'd0, a} - {8'd0, b};
      4'd4:    sc_res = {8'd0, a & b};
      4'd5:    sc_res = {8'd0, a | b};
      4'd6:    sc_res = {8'd0, a ^ b};
      default: sc_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = multi ? CALC : DONE;
      CALC:    if (cnt == 3'd7) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      a_r    <= 8'd0;
      b_r    <= 8'd0;
      cnt    <= 3'd0;
      acc    <= 16'd0;
      result <= 16'd0;
      err    <= 1'b0;
`ifdef ACCEL_SEQ_ALU_DIV_EN
      is_div_r <= 1'b0;
      rem      <= 8'd0;
      quo      <= 8'd0;
`endif
    end else begin
      case (state)
        IDLE: if (start) begin
          a_r <= a;
          b_r <= b;
          cnt <= 3'd0;
          acc <= 16'd0;
`ifdef ACCEL_SEQ_ALU_DIV_EN
          is_div_r <= (opcode == 4'd3);
          rem      <= 8'd0;
          quo      <= a;
`endif
          // Multi-cycle ops keep the old result visible until they finish.
          if (!multi) begin
            result <= sc_res;
            err    <= sc_err;
          end
        end
        CALC: begin
          cnt <= cnt + 3'd1;
          acc <= acc_nxt;
`ifdef ACCEL_SEQ_ALU_DIV_EN
          rem <= rem_nxt;
          quo <= quo_nxt;
`endif
          if (cnt == 3'd7) begin
`ifdef ACCEL_SEQ_ALU_DIV_EN
            if (is_div_r) begin
              result <= {rem_nxt, quo_nxt};
              err    <= (b_r == 8'd0);
            end else begin
              result <= acc_nxt;
              err    <= 1'b0;
            end
`else
            result <= acc_nxt;
            err    <= 1'b0;
`endif
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_accel_seq_alu.sv
// Scoreboard bench for accel_seq_alu: stimulus pushes expected responses, a forked monitor checks on done.
module tb_accel_seq_alu;
  logic        clk = 1'b0;
  logic        rst, start;
  logic [7:0]  a, b;
  logic [3:0]  opcode;
  logic        busy, done, err;
  logic [15:0] result;

  accel_seq_alu dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .opcode(opcode),
    .busy(busy), .done(done), .result(result), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] res;
    logic        err;
    int          edge_n;
    int          lat;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   done_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (done) begin
        done_cnt++;
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_done: done=1 with no pending op (cycle %0d)", cyc);
        end else begin
          e = q.pop_front();
          chk("result", {16'd0, result}, {16'd0, e.res});
          chk("err", {31'd0, err}, {31'd0, e.err});
          chk("latency", cyc - e.edge_n + 1, e.lat);
        end
      end
    end
  endtask

  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_, input logic [3:0] op,
                        input logic [15:0] xres, input logic xerr, input int lat);
    int nb, n;
    @(negedge clk);
    a = ta; b = tb_; opcode = op; start = 1'b1;
    q.push_back('{xres, xerr, cyc + 1, lat});
    nb = 0; n = 0;
    @(negedge clk);
    start = 1'b0;
    while ((busy || q.size() != 0) && n < 40) begin
      if (busy) nb++;
      n++;
      @(negedge clk);
    end
    if (n >= 40) begin
      checks++;
      errors++;
      $display("FAIL timeout: op %0h never completed", op);
      q.delete();
    end
    chk("busy_cycles", nb, lat);
  endtask

  initial begin
    int prev, n;
    rst = 1'b1; start = 1'b0; a = 8'd0; b = 8'd0; opcode = 4'd0;
    fork monitor(); join_none
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_result", {16'd0, result}, 0);
    chk("rst_err", {31'd0, err}, 0);

    run_op(8'd200, 8'd200, 4'd2, 16'h9C40, 1'b0, 9);
    run_op(8'h01,  8'h02,  4'd1, 16'hFFFF, 1'b0, 1);
    run_op(8'hFF,  8'h01,  4'd0, 16'h0100, 1'b0, 1);
    run_op(8'hF0,  8'h3C,  4'd4, 16'h0030, 1'b0, 1);
    run_op(8'hF0,  8'h0F,  4'd5, 16'h00FF, 1'b0, 1);
    run_op(8'hFF,  8'h0F,  4'd6, 16'h00F0, 1'b0, 1);
    run_op(8'h12,  8'h34,  4'hA, 16'h0000, 1'b1, 1);
    run_op(8'h00,  8'h00,  4'd0, 16'h0000, 1'b0, 1);
    run_op(8'h77,  8'h11,  4'hF, 16'h0000, 1'b1, 1);
`ifdef ACCEL_SEQ_ALU_DIV_EN
    run_op(8'd200, 8'd7,   4'd3, 16'h041C, 1'b0, 9);
    run_op(8'h55,  8'h00,  4'd3, 16'h55FF, 1'b1, 9);
`else
    run_op(8'd200, 8'd7,   4'd3, 16'h0000, 1'b1, 1);
`endif
    run_op(8'h0F,  8'h11,  4'd2, 16'h00FF, 1'b0, 9);

    // Reset mid-CALC: result holds during CALC, then reset clears without done.
    prev = done_cnt;
    @(negedge clk);
    a = 8'd3; b = 8'd5; opcode = 4'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("calc_busy", {31'd0, busy}, 1);
    chk("calc_hold_result", {16'd0, result}, 32'h00FF);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", {31'd0, busy}, 0);
    chk("abort_result", {16'd0, result}, 0);
    repeat (10) @(negedge clk);
    chk("abort_no_done", done_cnt - prev, 0);
    run_op(8'd3, 8'd5, 4'd2, 16'h000F, 1'b0, 9);

    // Start held high with churning operands: only the first launch counts.
    prev = done_cnt;
    @(negedge clk);
    a = 8'd3; b = 8'd5; opcode = 4'd2; start = 1'b1;
    q.push_back('{16'h000F, 1'b0, cyc + 1, 9});
    n = 0;
    do begin
      @(negedge clk);
      a = 8'(n * 37 + 11); b = 8'(n * 53 + 7); n++;
    end while (!done && n < 40);
    start = 1'b0;
    repeat (6) @(negedge clk);
    chk("single_done", done_cnt - prev, 1);
    chk("queue_drained", q.size(), 0);
    q.delete();

    // Reset wins over a simultaneous start.
    @(negedge clk);
    a = 8'h10; b = 8'h20; opcode = 4'd0; start = 1'b1; rst = 1'b1;
    @(negedge clk);
    start = 1'b0; rst = 1'b0;
    chk("rst_prio_busy", {31'd0, busy}, 0);
    chk("rst_prio_result", {16'd0, result}, 0);
    run_op(8'h10, 8'h20, 4'd0, 16'h0030, 1'b0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
